// File: rtl/fp32_add_align.sv
`default_nettype none
// ============================================================================
//  Module   : fp32_add_align
//  Purpose  : Two-stage operand-alignment front end for the FP32 adder.
//             Stage 1 unpacks both operands, applies the subtract sign
//             inversion and swaps so the larger magnitude comes first.
//             Stage 2 right-shifts the smaller significand by the exponent
//             difference through a 16/8/4/2/1 log shifter and forms sticky.
//  Ports    : i_clk, i_rst_n (async, active-low)
//             i_valid/o_ready   - input handshake, operands i_a, i_b, i_sub
//             o_valid/i_ready   - output handshake
//             o_sig_big, o_sig_small, o_sticky, o_exp,
//             o_sign_big, o_sign_small, o_eff_sub, o_special
//  Config   : FP_ALIGN_STICKY_EN - when defined, o_sticky carries the OR of
//             all bits shifted out; otherwise o_sticky is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module fp32_add_align (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_sub,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_sig_big,
  output logic [31:0] o_sig_small,
  output logic        o_sticky,
  output logic [7:0]  o_exp,
  output logic        o_sign_big,
  output logic        o_sign_small,
  output logic        o_eff_sub,
  output logic        o_special
);

  localparam logic [7:0] EXP_SPECIAL = 8'hFF;

  // --------------------------------------------------------------------------
  // Unpack and compare (feeds stage 1)
  // --------------------------------------------------------------------------
  logic        a_sign, b_sign;
  logic [7:0]  a_exp, b_exp, a_eff_exp, b_eff_exp;
  logic [22:0] a_frac, b_frac;
  logic [31:0] a_sig, b_sig;
  logic        swap;
  logic        in_special;

  always_comb begin
    a_sign     = i_a[31];
    b_sign     = i_b[31] ^ i_sub;
    a_exp      = i_a[30:23];
    b_exp      = i_b[30:23];
    a_frac     = i_a[22:0];
    b_frac     = i_b[22:0];
    // Subnormals use exponent 1 so they align against normals correctly.
    a_eff_exp  = (a_exp == 8'd0) ? 8'd1 : a_exp;
    b_eff_exp  = (b_exp == 8'd0) ? 8'd1 : b_exp;
    a_sig      = {(a_exp != 8'd0), a_frac, 8'd0};
    b_sig      = {(b_exp != 8'd0), b_frac, 8'd0};
    // Strictly greater: on a tie A stays the big operand.
    swap       = ({b_eff_exp, b_frac} > {a_eff_exp, a_frac});
    in_special = (a_exp == EXP_SPECIAL) || (b_exp == EXP_SPECIAL);
  end

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic advance;
  logic s1_take;

  assign advance = !s2_valid_q || i_ready;
  assign o_ready = !s1_valid_q || advance;
  assign s1_take = i_valid && o_ready;

  // --------------------------------------------------------------------------
  // Stage 1 registers
  // --------------------------------------------------------------------------
  logic [31:0] s1_sig_big_q, s1_sig_big_d;
  logic [31:0] s1_sig_small_q, s1_sig_small_d;
  logic [7:0]  s1_diff_q, s1_diff_d;
  logic [7:0]  s1_exp_q, s1_exp_d;
  logic        s1_sign_big_q, s1_sign_big_d;
  logic        s1_sign_small_q, s1_sign_small_d;
  logic        s1_special_q, s1_special_d;

  always_comb begin
    s1_valid_d      = s1_valid_q;
    s1_sig_big_d    = s1_sig_big_q;
    s1_sig_small_d  = s1_sig_small_q;
    s1_diff_d       = s1_diff_q;
    s1_exp_d        = s1_exp_q;
    s1_sign_big_d   = s1_sign_big_q;
    s1_sign_small_d = s1_sign_small_q;
    s1_special_d    = s1_special_q;
    if (o_ready) begin
      s1_valid_d = i_valid;
    end
    if (s1_take) begin
      s1_special_d = in_special;
      if (swap) begin
        s1_sig_big_d    = b_sig;
        s1_sig_small_d  = a_sig;
        s1_diff_d       = b_eff_exp - a_eff_exp;
        s1_exp_d        = b_eff_exp;
        s1_sign_big_d   = b_sign;
        s1_sign_small_d = a_sign;
      end else begin
        s1_sig_big_d    = a_sig;
        s1_sig_small_d  = b_sig;
        s1_diff_d       = a_eff_exp - b_eff_exp;
        s1_exp_d        = a_eff_exp;
        s1_sign_big_d   = a_sign;
        s1_sign_small_d = b_sign;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2 alignment shifter
  // --------------------------------------------------------------------------
  logic [4:0]  amt;
  logic        flush;
  logic [31:0] sh16, sh8, sh4, sh2, sh1;
  logic [31:0] aligned;
  logic        sticky;

  always_comb begin
    // Inf/NaN pass through unshifted; resolution happens downstream.
    amt     = s1_special_q ? 5'd0 : s1_diff_q[4:0];
    flush   = !s1_special_q && (s1_diff_q[7:5] != 3'd0);
    sh16    = amt[4] ? {16'd0, s1_sig_small_q[31:16]} : s1_sig_small_q;
    sh8     = amt[3] ? {8'd0, sh16[31:8]} : sh16;
    sh4     = amt[2] ? {4'd0, sh8[31:4]}  : sh8;
    sh2     = amt[1] ? {2'd0, sh4[31:2]}  : sh4;
    sh1     = amt[0] ? {1'd0, sh2[31:1]}  : sh2;
    aligned = flush ? 32'd0 : sh1;
  end

`ifdef FP_ALIGN_STICKY_EN
  always_comb begin
    // Each enabled stage contributes the bits it drops off the bottom.
    sticky = (amt[4] & (|s1_sig_small_q[15:0])) |
             (amt[3] & (|sh16[7:0]))            |
             (amt[2] & (|sh8[3:0]))             |
             (amt[1] & (|sh4[1:0]))             |
             (amt[0] & sh2[0]);
    if (flush) begin
      sticky = |s1_sig_small_q;
    end
  end
`else
  assign sticky = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Stage 2 registers
  // --------------------------------------------------------------------------
  logic [31:0] s2_sig_big_q, s2_sig_big_d;
  logic [31:0] s2_sig_small_q, s2_sig_small_d;
  logic        s2_sticky_q, s2_sticky_d;
  logic [7:0]  s2_exp_q, s2_exp_d;
  logic        s2_sign_big_q, s2_sign_big_d;
  logic        s2_sign_small_q, s2_sign_small_d;
  logic        s2_special_q, s2_special_d;

  always_comb begin
    s2_valid_d      = s2_valid_q;
    s2_sig_big_d    = s2_sig_big_q;
    s2_sig_small_d  = s2_sig_small_q;
    s2_sticky_d     = s2_sticky_q;
    s2_exp_d        = s2_exp_q;
    s2_sign_big_d   = s2_sign_big_q;
    s2_sign_small_d = s2_sign_small_q;
    s2_special_d    = s2_special_q;
    if (advance) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_sig_big_d    = s1_sig_big_q;
        s2_sig_small_d  = aligned;
        s2_sticky_d     = sticky;
        s2_exp_d        = s1_exp_q;
        s2_sign_big_d   = s1_sign_big_q;
        s2_sign_small_d = s1_sign_small_q;
        s2_special_d    = s1_special_q;
      end
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q      <= 1'b0;
      s1_sig_big_q    <= 32'd0;
      s1_sig_small_q  <= 32'd0;
      s1_diff_q       <= 8'd0;
      s1_exp_q        <= 8'd0;
      s1_sign_big_q   <= 1'b0;
      s1_sign_small_q <= 1'b0;
      s1_special_q    <= 1'b0;
      s2_valid_q      <= 1'b0;
      s2_sig_big_q    <= 32'd0;
      s2_sig_small_q  <= 32'd0;
      s2_sticky_q     <= 1'b0;
      s2_exp_q        <= 8'd0;
      s2_sign_big_q   <= 1'b0;
      s2_sign_small_q <= 1'b0;
      s2_special_q    <= 1'b0;
    end else begin
      s1_valid_q      <= s1_valid_d;
      s1_sig_big_q    <= s1_sig_big_d;
      s1_sig_small_q  <= s1_sig_small_d;
      s1_diff_q       <= s1_diff_d;
      s1_exp_q        <= s1_exp_d;
      s1_sign_big_q   <= s1_sign_big_d;
      s1_sign_small_q <= s1_sign_small_d;
      s1_special_q    <= s1_special_d;
      s2_valid_q      <= s2_valid_d;
      s2_sig_big_q    <= s2_sig_big_d;
      s2_sig_small_q  <= s2_sig_small_d;
      s2_sticky_q     <= s2_sticky_d;
      s2_exp_q        <= s2_exp_d;
      s2_sign_big_q   <= s2_sign_big_d;
      s2_sign_small_q <= s2_sign_small_d;
      s2_special_q    <= s2_special_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign o_valid      = s2_valid_q;
  assign o_sig_big    = s2_sig_big_q;
  assign o_sig_small  = s2_sig_small_q;
  assign o_sticky     = s2_sticky_q;
  assign o_exp        = s2_exp_q;
  assign o_sign_big   = s2_sign_big_q;
  assign o_sign_small = s2_sign_small_q;
  assign o_eff_sub    = s2_sign_big_q ^ s2_sign_small_q;
  assign o_special    = s2_special_q;

endmodule
`default_nettype wire
